dec_issue_queue: RTL and testbench

Consumer-side buffer for the instruction decoder. It accepts up to two `DecoderDataType` records per cycle from the decode stage (`DEC_NUM` = 2 lanes) and holds them in a circular queue. It issues them in program order, one per cycle, to the executor over a valid/ready handshake. The queue decouples decode throughput from execute stalls and is emptied by a pipeline flush (branch mispredict, trap, debug halt).

---
 rtl/decoder_pkg.sv | 18 +
 rtl/dec_issue_queue.sv | 90 +++++++++
 tb/tb_dec_issue_queue.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/decoder_pkg.sv
// decoder_pkg: decoder record type, lane count and issue-queue depth shared by the decode/issue slice
package decoder_pkg;

    localparam int DEC_NUM = 2;
    localparam int CFG_ISSUE_DEPTH = 8;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [3:0]  op;
    } DecoderDataType;

    localparam DecoderDataType decoder_data_none = '0;

endpackage

// File: rtl/dec_issue_queue.sv
// dec_issue_queue: two-lane decode buffer issuing one record per cycle in program order
//   i_clk, i_rst (async, active-high), i_flush   : clock, reset, discard all entries
//   i_d0_valid/i_d0, i_d1_valid/i_d1            : decode lanes (d0 older than d1)
//   o_wready                                     : at least two free entries
//   o_valid/o_d/i_ready                          : head record handshake to the executor
//   o_count                                      : occupied entries
//   o_drop                                       : registered pulse, a presented record was discarded
module dec_issue_queue
    import decoder_pkg::*;
#(
    parameter int DEPTH = CFG_ISSUE_DEPTH
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_flush,
    input  logic                     i_d0_valid,
    input  DecoderDataType           i_d0,
    input  logic                     i_d1_valid,
    input  DecoderDataType           i_d1,
    output logic                     o_wready,
    output logic                     o_valid,
    output DecoderDataType           o_d,
    input  logic                     i_ready,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_drop
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        DecoderDataType [DEPTH-1:0] mem;
        logic [AW-1:0]              wr_ptr;
        logic [AW-1:0]              rd_ptr;
        logic [CW-1:0]              count;
        logic                       drop;
    } dec_issue_queue_registers;

    localparam dec_issue_queue_registers dec_issue_queue_r_reset = '{
        mem:    '0,
        wr_ptr: '0,
        rd_ptr: '0,
        count:  '0,
        drop:   1'b0
    };

    dec_issue_queue_registers r, rin;
    logic          wready, push, wr0, wr1, pop, drop;
    logic [1:0]    npush;
    logic [AW-1:0] wp1;

    // Conservative: a single free slot is refused so the decoder can always present a full pair.
    assign wready = r.count <= CW'(DEPTH - 2);
    assign push   = wready & ~i_flush;
    assign wr0    = push & i_d0_valid;
    assign wr1    = wr0 & i_d1_valid;
    assign npush  = {1'b0, wr0} + {1'b0, wr1};
    assign pop    = (r.count != '0) & i_ready & ~i_flush;
    assign wp1    = r.wr_ptr + AW'(1);
    // d1 without d0, or anything presented while full, is a decoder protocol error.
    assign drop   = ~i_flush & ((i_d1_valid & ~i_d0_valid) | ((i_d0_valid | i_d1_valid) & ~wready));

    always_comb begin
        rin = r;
        if (i_flush) begin
            rin.wr_ptr = '0;
            rin.rd_ptr = '0;
            rin.count  = '0;
        end else begin
            if (wr0) rin.mem[r.wr_ptr] = i_d0;
            if (wr1) rin.mem[wp1] = i_d1;
            rin.wr_ptr = r.wr_ptr + AW'(npush);
            rin.rd_ptr = r.rd_ptr + AW'(pop);
            rin.count  = r.count + CW'(npush) - CW'(pop);
        end
        rin.drop = drop;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r <= dec_issue_queue_r_reset;
        else r <= rin;
    end

    assign o_wready = wready;
    assign o_valid  = r.count != '0;
    assign o_d      = r.mem[r.rd_ptr];
    assign o_count  = r.count;
    assign o_drop   = r.drop;

endmodule

// File: tb/tb_dec_issue_queue.sv
// tb_dec_issue_queue: directed + random check of dec_issue_queue against a queue-based model
module tb_dec_issue_queue;
    import decoder_pkg::*;

    localparam int DEPTH = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           flush = 1'b0;
    logic           d0v = 1'b0, d1v = 1'b0, ready = 1'b0;
    DecoderDataType d0 = '0, d1 = '0;
    logic           wready, valid, drop;
    DecoderDataType od;
    logic [3:0]     count;

    int errors = 0;
    int checks = 0;

    DecoderDataType q[$];
    bit             drop_exp = 1'b0;

    dec_issue_queue #(.DEPTH(DEPTH)) dut (
        .i_clk(clk), .i_rst(rst), .i_flush(flush),
        .i_d0_valid(d0v), .i_d0(d0), .i_d1_valid(d1v), .i_d1(d1),
        .o_wready(wready), .o_valid(valid), .o_d(od), .i_ready(ready),
        .o_count(count), .o_drop(drop)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: occupancy is the queue length; pop sees the old head, pushes append in lane order.
    always @(posedge clk or posedge rst) begin
        int  free;
        bit  acc;
        if (rst || flush) begin
            q.delete();
            drop_exp = 1'b0;
        end else begin
            free = DEPTH - q.size();
            acc = free >= 2;
            drop_exp = (d1v && !d0v) || ((d0v || d1v) && !acc);
            if (q.size() > 0 && ready) void'(q.pop_front());
            if (acc && d0v) begin
                q.push_back(d0);
                if (d1v) q.push_back(d1);
            end
        end
    end

    always @(negedge clk) begin
        chk("count", count, q.size());
        chk("valid", valid, q.size() != 0);
        chk("wready", wready, (DEPTH - q.size()) >= 2);
        chk("drop", drop, drop_exp);
        if (!rst && q.size() != 0) chk("o_d", od, q[0]);
    end

    function automatic DecoderDataType rec(input logic [31:0] pc);
        DecoderDataType r;
        r.pc    = pc;
        r.instr = $urandom;
        r.rd    = 5'($urandom);
        r.rs1   = 5'($urandom);
        r.rs2   = 5'($urandom);
        r.op    = 4'($urandom);
        return r;
    endfunction

    task automatic drive(input bit v0, input logic [31:0] pc0, input bit v1, input logic [31:0] pc1,
                         input bit rdy, input bit fl);
        d0v = v0; d0 = rec(pc0);
        d1v = v1; d1 = rec(pc1);
        ready = rdy; flush = fl;
        @(negedge clk);
    endtask

    task automatic idle(input bit rdy);
        drive(0, 0, 0, 0, rdy, 0);
    endtask

    initial begin
        #2;
        chk("rst_valid", valid, 0);
        chk("rst_wready", wready, 1);
        chk("rst_count", count, 0);
        chk("rst_drop", drop, 0);
        chk("rst_od", od, decoder_data_none);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        drive(1, 32'h1000, 1, 32'h1004, 0, 0);
        chk("pair_valid", valid, 1);
        chk("pair_pc", od.pc, 32'h1000);
        chk("pair_count", count, 2);
        idle(1);
        chk("pop1_pc", od.pc, 32'h1004);
        idle(1);
        chk("pop2_valid", valid, 0);

        for (int i = 0; i < 4; i++) begin
            drive(1, 32'h100 + 8 * i, 1, 32'h104 + 8 * i, 0, 0);
            chk("fill_count", count, 2 * (i + 1));
            chk("fill_wready", wready, i < 3);
        end
        drive(1, 32'h500, 0, 0, 0, 0);
        chk("full_drop", drop, 1);
        chk("full_count", count, 8);
        idle(0);
        chk("drop_pulse", drop, 0);

        drive(0, 0, 0, 0, 0, 1);
        drive(1, 32'h3000, 1, 32'h3004, 0, 0);
        drive(1, 32'h3008, 1, 32'h300c, 0, 0);
        drive(1, 32'h3010, 1, 32'h3014, 0, 0);
        drive(1, 32'h3018, 0, 0, 1, 0);
        chk("w7_count", count, 6);
        drive(1, 32'h301c, 1, 32'h3020, 1, 0);
        chk("wrap_count", count, 7);
        chk("wrap_wready", wready, 0);
        for (int i = 0; i < 7; i++) begin
            chk("wrap_order", od.pc, 32'h3008 + 4 * i);
            idle(1);
        end
        chk("wrap_empty", valid, 0);

        drive(1, 32'h4000, 1, 32'h4004, 0, 0);
        drive(1, 32'h4008, 1, 32'h400c, 0, 0);
        drive(1, 32'h4010, 0, 0, 0, 0);
        chk("pre_flush", count, 5);
        drive(1, 32'h4014, 0, 0, 1, 1);
        chk("flush_count", count, 0);
        chk("flush_valid", valid, 0);

        drive(0, 0, 1, 32'h4444, 0, 0);
        chk("d1only_count", count, 0);
        chk("d1only_drop", drop, 1);
        idle(0);
        chk("d1only_pulse", drop, 0);

        drive(1, 32'h5000, 1, 32'h5004, 0, 0);
        drive(1, 32'h5008, 0, 0, 0, 0);
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", valid, 0);
        chk("arst_count", count, 0);
        @(negedge clk);
        rst = 1'b0;
        drive(1, 32'h2000, 0, 0, 0, 0);
        chk("post_rst_pc", od.pc, 32'h2000);
        idle(1);

        for (int i = 0; i < 3000; i++) begin
            bit a, b;
            a = $urandom_range(0, 3) != 0;
            b = $urandom_range(0, 7) == 0 ? !a && $urandom_range(0, 1) : a && $urandom_range(0, 1);
            drive(a, $urandom, b, $urandom, $urandom_range(0, 2) == 0, $urandom_range(0, 47) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
